// File: rtl/ctiq_pkg.sv
// Shared types and sizing for the CTI queue: branch-type encoding, entry state and entry payload.
package ctiq_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned INDEX = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned BRT_W = 2;

  localparam logic [BRT_W-1:0] BRT_COND   = 2'd0;
  localparam logic [BRT_W-1:0] BRT_JUMP   = 2'd1;
  localparam logic [BRT_W-1:0] BRT_CALL   = 2'd2;
  localparam logic [BRT_W-1:0] BRT_RETURN = 2'd3;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ALLOC     = 2'd1,
    ST_RESOLVED  = 2'd2,
    ST_COMMITTED = 2'd3
  } ctiq_state_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [BRT_W-1:0] brtype;
    logic             taken;
    logic [PC_W-1:0]  target;
    ctiq_state_e      state;
  } ctiq_entry_t;

endpackage

// File: rtl/cti_queue_if.sv
// Fetch/execute/commit/update signal bundle of the CTI queue; slave is the queue side.
interface cti_queue_if;
  import ctiq_pkg::*;

  logic             enq_valid_i;
  logic [PC_W-1:0]  enq_pc_i;
  logic [BRT_W-1:0] enq_brtype_i;
  logic             enq_ready_o;
  logic [INDEX-1:0] enq_idx_o;

  logic             exe_valid_i;
  logic [INDEX-1:0] exe_idx_i;
  logic             exe_taken_i;
  logic [PC_W-1:0]  exe_target_i;

  logic             recover_i;
  logic [INDEX-1:0] recover_idx_i;
  logic             exception_i;
  logic             commit_valid_i;

  logic             update_stall_i;
  logic             update_en_o;
  logic [PC_W-1:0]  update_pc_o;
  logic [BRT_W-1:0] update_br_type_o;
  logic             update_taken_o;
  logic [PC_W-1:0]  update_target_o;
  logic             empty_o;

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_brtype_i,
    input  exe_valid_i, exe_idx_i, exe_taken_i, exe_target_i,
    input  recover_i, recover_idx_i, exception_i, commit_valid_i, update_stall_i,
    output enq_ready_o, enq_idx_o,
    output update_en_o, update_pc_o, update_br_type_o, update_taken_o, update_target_o,
    output empty_o
  );

  modport master (
    output enq_valid_i, enq_pc_i, enq_brtype_i,
    output exe_valid_i, exe_idx_i, exe_taken_i, exe_target_i,
    output recover_i, recover_idx_i, exception_i, commit_valid_i, update_stall_i,
    input  enq_ready_o, enq_idx_o,
    input  update_en_o, update_pc_o, update_br_type_o, update_taken_o, update_target_o,
    input  empty_o
  );

endinterface

// File: rtl/cti_queue_ram.sv
// CTI entry payload storage: enqueue write port, execute write port, asynchronous drain read port.
module cti_queue_ram
  import ctiq_pkg::*;
(
  input  logic             clk,
  input  logic             enq_we_i,
  input  logic [INDEX-1:0] enq_idx_i,
  input  logic [PC_W-1:0]  enq_pc_i,
  input  logic [BRT_W-1:0] enq_brtype_i,
  input  logic             exe_we_i,
  input  logic [INDEX-1:0] exe_idx_i,
  input  logic             exe_taken_i,
  input  logic [PC_W-1:0]  exe_target_i,
  input  logic [INDEX-1:0] rd_idx_i,
  input  ctiq_state_e      rd_state_i,
  output ctiq_entry_t      rd_entry_c_o
);

  logic [PC_W-1:0]  pc_q     [DEPTH];
  logic [BRT_W-1:0] brtype_q [DEPTH];
  logic             taken_q  [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];

  always_ff @(posedge clk) begin
    if (enq_we_i) begin
      pc_q[enq_idx_i]     <= enq_pc_i;
      brtype_q[enq_idx_i] <= enq_brtype_i;
    end
    if (exe_we_i) begin
      taken_q[exe_idx_i]  <= exe_taken_i;
      target_q[exe_idx_i] <= exe_target_i;
    end
  end

  // State lives in the control logic; it is merged here so the drain sees one entry.
  assign rd_entry_c_o = '{pc:     pc_q[rd_idx_i],
                          brtype: brtype_q[rd_idx_i],
                          taken:  taken_q[rd_idx_i],
                          target: target_q[rd_idx_i],
                          state:  rd_state_i};

endmodule

// File: rtl/cti_queue.sv
// In-order CTI queue: allocate at fetch, resolve at execute, commit in order, drain as update stream.
// Optional perf counters enabled by defining CTI_QUEUE_PERF_EN.
module cti_queue
  import ctiq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  cti_queue_if.slave  bus
`ifdef CTI_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_updates_o,
  output logic [31:0] perf_full_cycles_o,
  output logic [31:0] perf_squashed_o
`endif
);

  localparam int unsigned PTR_W = INDEX + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [INDEX-1:0] idx_t;

  ptr_t head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  ctiq_state_e state_q [DEPTH];
  ctiq_state_e state_d [DEPTH];

  logic             update_en_q, update_en_d;
  logic [PC_W-1:0]  update_pc_q, update_pc_d;
  logic [BRT_W-1:0] update_brt_q, update_brt_d;
  logic             update_taken_q, update_taken_d;
  logic [PC_W-1:0]  update_target_q, update_target_d;

  idx_t        head_idx, cmt_idx, tail_idx, rec_off;
  ptr_t        count, new_count, rec_tail;
  logic        full, flush, enq_fire, exe_hit, commit_ok, drain_fire;
  logic [DEPTH-1:0] squash_vec;
  ctiq_entry_t head_entry;
  ctiq_state_e cmt_state;

  assign head_idx = head_q[INDEX-1:0];
  assign cmt_idx  = cmt_q[INDEX-1:0];
  assign tail_idx = tail_q[INDEX-1:0];

  assign count = tail_q - head_q;
  assign full  = (count == PTR_W'(DEPTH));

  assign bus.enq_ready_o = ~full;
  assign bus.enq_idx_o   = tail_idx;
  assign bus.empty_o     = (count == '0);

  assign flush      = bus.exception_i | bus.recover_i;
  assign enq_fire   = bus.enq_valid_i & ~full & ~flush;
  assign exe_hit    = bus.exe_valid_i & (state_q[bus.exe_idx_i] == ST_ALLOC);
  assign commit_ok  = bus.commit_valid_i & ~bus.exception_i & (cmt_q != tail_q);
  assign drain_fire = (head_entry.state == ST_COMMITTED) & ~bus.update_stall_i;
  assign cmt_state  = state_q[cmt_idx];

  // Mispredicted entry's wrap bit comes from its distance to head.
  assign rec_off  = bus.recover_idx_i - head_idx;
  assign rec_tail = head_q + PTR_W'(rec_off) + PTR_W'(1);

  cti_queue_ram u_ram (
    .clk          (clk),
    .enq_we_i     (enq_fire),
    .enq_idx_i    (tail_idx),
    .enq_pc_i     (bus.enq_pc_i),
    .enq_brtype_i (bus.enq_brtype_i),
    .exe_we_i     (exe_hit),
    .exe_idx_i    (bus.exe_idx_i),
    .exe_taken_i  (bus.exe_taken_i),
    .exe_target_i (bus.exe_target_i),
    .rd_idx_i     (head_idx),
    .rd_state_i   (state_q[head_idx]),
    .rd_entry_c_o (head_entry)
  );

  always_comb begin
    head_d = head_q + PTR_W'(drain_fire);
    cmt_d  = cmt_q + PTR_W'(commit_ok);
    tail_d = tail_q;
    if (bus.exception_i)   tail_d = cmt_q;
    else if (bus.recover_i) tail_d = rec_tail;
    else if (enq_fire)      tail_d = tail_q + PTR_W'(1);
  end

  assign new_count = tail_d - head_q;

  // Entries between the new and old tail (relative to head) are squashed.
  always_comb begin : squash_calc
    idx_t off;
    ptr_t rel;
    squash_vec = '0;
    off = '0;
    rel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = INDEX'(i) - head_idx;
      rel = PTR_W'(off);
      squash_vec[i] = flush & (rel >= new_count) & (rel < count);
    end
  end

  always_comb begin
    state_d = state_q;
    if (drain_fire) state_d[head_idx]        = ST_FREE;
    if (enq_fire)   state_d[tail_idx]        = ST_ALLOC;
    if (exe_hit)    state_d[bus.exe_idx_i]   = ST_RESOLVED;
    if (commit_ok)  state_d[cmt_idx]         = ST_COMMITTED;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (squash_vec[i]) state_d[i] = ST_FREE;
    end
  end

  always_comb begin
    update_en_d     = drain_fire;
    update_pc_d     = update_pc_q;
    update_brt_d    = update_brt_q;
    update_taken_d  = update_taken_q;
    update_target_d = update_target_q;
    if (drain_fire) begin
      update_pc_d     = head_entry.pc;
      update_brt_d    = head_entry.brtype;
      update_taken_d  = head_entry.taken;
      update_target_d = head_entry.target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q          <= '0;
      cmt_q           <= '0;
      tail_q          <= '0;
      update_en_q     <= 1'b0;
      update_pc_q     <= '0;
      update_brt_q    <= '0;
      update_taken_q  <= 1'b0;
      update_target_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
    end else begin
      head_q          <= head_d;
      cmt_q           <= cmt_d;
      tail_q          <= tail_d;
      update_en_q     <= update_en_d;
      update_pc_q     <= update_pc_d;
      update_brt_q    <= update_brt_d;
      update_taken_q  <= update_taken_d;
      update_target_q <= update_target_d;
      state_q         <= state_d;
    end
  end

  assign bus.update_en_o      = update_en_q;
  assign bus.update_pc_o      = update_pc_q;
  assign bus.update_br_type_o = update_brt_q;
  assign bus.update_taken_o   = update_taken_q;
  assign bus.update_target_o  = update_target_q;

  a_commit_not_empty: assert property (@(posedge clk) disable iff (!reset)
    bus.commit_valid_i |-> (cmt_q != tail_q));

  a_commit_resolved: assert property (@(posedge clk) disable iff (!reset)
    commit_ok |-> (cmt_state != ST_ALLOC));

`ifdef CTI_QUEUE_PERF_EN
  logic [31:0] perf_upd_q, perf_full_q, perf_sq_q;
  ptr_t        sq_cnt;
  logic [32:0] sq_sum;

  assign sq_cnt = (flush && (new_count < count)) ? (count - new_count) : '0;
  assign sq_sum = 33'(perf_sq_q) + 33'(sq_cnt);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_upd_q  <= '0;
      perf_full_q <= '0;
      perf_sq_q   <= '0;
    end else begin
      if (update_en_q && (perf_upd_q != '1)) perf_upd_q <= perf_upd_q + 32'd1;
      if (bus.enq_valid_i && full && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
      perf_sq_q <= sq_sum[32] ? '1 : sq_sum[31:0];
    end
  end

  assign perf_updates_o     = perf_upd_q;
  assign perf_full_cycles_o = perf_full_q;
  assign perf_squashed_o    = perf_sq_q;
`endif

endmodule

// File: tb/tb_cti_queue.sv
// Self-checking bench for cti_queue: directed scenarios plus random traffic against a list-based model.
module tb_cti_queue;
  import ctiq_pkg::*;

  logic clk;
  logic rst_n;
  cti_queue_if bus();

`ifdef CTI_QUEUE_PERF_EN
  logic [31:0] perf_upd, perf_full, perf_sq;
`endif

  cti_queue dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef CTI_QUEUE_PERF_EN
    ,
    .perf_updates_o     (perf_upd),
    .perf_full_cycles_o (perf_full),
    .perf_squashed_o    (perf_sq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [1:0]  bt;
    bit          res;
    bit          tk;
    logic [31:0] tgt;
    bit          cm;
  } ment_t;

  ment_t       mq[$];
  int          next_id;
  bit          exp_en;
  logic [31:0] exp_pc, exp_tgt;
  logic [1:0]  exp_bt;
  bit          exp_tk;

  int n_checks = 0;
  int n_errors = 0;
  int upd_seen = 0;
  int upd_since_rst = 0;

  bit          s_enq, s_exe, s_exe_tk, s_rec, s_exc, s_cmt, s_stall, s_rst_n;
  logic [31:0] s_pc, s_exe_tgt;
  logic [1:0]  s_bt;
  logic [3:0]  s_exe_idx, s_rec_idx;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_unc();
    foreach (mq[k]) if (!mq[k].cm) return k;
    return mq.size();
  endfunction

  task automatic clr();
    s_enq = 0; s_exe = 0; s_exe_tk = 0; s_rec = 0; s_exc = 0; s_cmt = 0; s_stall = 0; s_rst_n = 1;
    s_pc = '0; s_exe_tgt = '0; s_bt = '0; s_exe_idx = '0; s_rec_idx = '0;
  endtask

  // Queue semantics as list operations on the pre-edge state.
  task automatic model_step();
    ment_t e;
    int fu;
    bit was_full;
    if (!s_rst_n) begin
      mq.delete(); next_id = 0; exp_en = 0;
      exp_pc = '0; exp_tgt = '0; exp_bt = '0; exp_tk = 0;
      upd_since_rst = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    exp_en = (mq.size() > 0) && mq[0].cm && !s_stall;
    if (exp_en) begin
      exp_pc = mq[0].pc; exp_bt = mq[0].bt; exp_tk = mq[0].tk; exp_tgt = mq[0].tgt;
      void'(mq.pop_front());
    end
    if (s_exe) begin
      foreach (mq[k]) if (mq[k].id == int'(s_exe_idx) && !mq[k].res) begin
        mq[k].res = 1; mq[k].tk = s_exe_tk; mq[k].tgt = s_exe_tgt;
      end
    end
    if (s_cmt && !s_exc) begin
      fu = first_unc();
      if (fu < mq.size()) mq[fu].cm = 1;
    end
    if (s_exc) begin
      while (mq.size() > 0 && !mq[mq.size()-1].cm) begin
        void'(mq.pop_back());
        next_id = (next_id + DEPTH - 1) % DEPTH;
      end
    end else if (s_rec) begin
      while (mq.size() > 0 && mq[mq.size()-1].id != int'(s_rec_idx)) void'(mq.pop_back());
      next_id = (int'(s_rec_idx) + 1) % DEPTH;
    end else if (s_enq && !was_full) begin
      e = '{id: next_id, pc: s_pc, bt: s_bt, res: 0, tk: 0, tgt: '0, cm: 0};
      mq.push_back(e);
      next_id = (next_id + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    check_eq("update_en", 64'(bus.update_en_o), 64'(exp_en));
    check_eq("update_pc", 64'(bus.update_pc_o), 64'(exp_pc));
    check_eq("update_type", 64'(bus.update_br_type_o), 64'(exp_bt));
    check_eq("update_taken", 64'(bus.update_taken_o), 64'(exp_tk));
    check_eq("update_target", 64'(bus.update_target_o), 64'(exp_tgt));
    check_eq("enq_ready", 64'(bus.enq_ready_o), 64'(mq.size() < DEPTH));
    check_eq("enq_idx", 64'(bus.enq_idx_o), 64'(next_id));
    check_eq("empty", 64'(bus.empty_o), 64'(mq.size() == 0));
    if (bus.update_en_o) begin
      upd_seen++;
      upd_since_rst++;
    end
  endtask

  // Inputs are driven at the falling edge; outputs checked at the next falling edge.
  task automatic tick();
    rst_n              = s_rst_n;
    bus.enq_valid_i    = s_enq;
    bus.enq_pc_i       = s_pc;
    bus.enq_brtype_i   = s_bt;
    bus.exe_valid_i    = s_exe;
    bus.exe_idx_i      = s_exe_idx;
    bus.exe_taken_i    = s_exe_tk;
    bus.exe_target_i   = s_exe_tgt;
    bus.recover_i      = s_rec;
    bus.recover_idx_i  = s_rec_idx;
    bus.exception_i    = s_exc;
    bus.commit_valid_i = s_cmt;
    bus.update_stall_i = s_stall;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_rst();                       clr(); s_rst_n = 0; tick(); endtask
  task automatic idle(input int n);              repeat (n) begin clr(); tick(); end endtask
  task automatic do_cmt();                       clr(); s_cmt = 1; tick(); endtask
  task automatic do_enq(input logic [31:0] pc, input logic [1:0] bt);
    clr(); s_enq = 1; s_pc = pc; s_bt = bt; tick();
  endtask
  task automatic do_exe(input int id, input bit tk, input logic [31:0] tgt);
    clr(); s_exe = 1; s_exe_idx = 4'(id); s_exe_tk = tk; s_exe_tgt = tgt; tick();
  endtask

  initial begin
    int base;
    int fu;
    clr();
    do_rst();
    check_eq("rst_update_en", 64'(bus.update_en_o), 64'd0);
    check_eq("rst_empty", 64'(bus.empty_o), 64'd1);
    check_eq("rst_enq_ready", 64'(bus.enq_ready_o), 64'd1);

    // Single CALL through the whole pipeline.
    check_eq("t1_idx0", 64'(bus.enq_idx_o), 64'd0);
    do_enq(32'h1000, BRT_CALL);
    do_exe(0, 1, 32'h2000);
    do_cmt();
    check_eq("t1_no_early_update", 64'(bus.update_en_o), 64'd0);
    idle(1);
    check_eq("t1_en", 64'(bus.update_en_o), 64'd1);
    check_eq("t1_pc", 64'(bus.update_pc_o), 64'h1000);
    check_eq("t1_type", 64'(bus.update_br_type_o), 64'(BRT_CALL));
    check_eq("t1_target", 64'(bus.update_target_o), 64'h2000);
    idle(1);
    check_eq("t1_empty_after", 64'(bus.empty_o), 64'd1);

    // Fill to full, drop the 17th, free one slot and wrap.
    do_rst();
    for (int i = 0; i < 16; i++) do_enq(32'h4000 + 32'(i * 4), BRT_COND);
    check_eq("t2_full", 64'(bus.enq_ready_o), 64'd0);
    do_enq(32'hdead, BRT_JUMP);
    check_eq("t2_full_hold", 64'(bus.enq_ready_o), 64'd0);
    do_exe(0, 0, 32'h5000);
    do_cmt();
    idle(1);
    check_eq("t2_ready_again", 64'(bus.enq_ready_o), 64'd1);
    check_eq("t2_wrap_idx", 64'(bus.enq_idx_o), 64'd0);

    // Recover at id 2 with an enqueue in the same cycle.
    do_rst();
    for (int i = 0; i < 6; i++) do_enq(32'h100 * 32'(i + 1), BRT_JUMP);
    clr(); s_rec = 1; s_rec_idx = 4'd2; s_enq = 1; s_pc = 32'hbad; tick();
    check_eq("t3_rec_idx", 64'(bus.enq_idx_o), 64'd3);
    do_exe(4, 1, 32'h9999);
    for (int i = 0; i < 3; i++) do_exe(i, 1, 32'h7000 + 32'(i));
    base = upd_seen;
    for (int i = 0; i < 3; i++) do_cmt();
    idle(4);
    check_eq("t3_updates", 64'(upd_seen - base), 64'd3);

    // Exception after two commits, overriding a same-cycle commit and enqueue.
    do_rst();
    for (int i = 0; i < 4; i++) do_enq(32'h200 * 32'(i + 1), BRT_RETURN);
    for (int i = 0; i < 4; i++) do_exe(i, 1, 32'h8000 + 32'(i));
    base = upd_seen;
    do_cmt();
    do_cmt();
    clr(); s_exc = 1; s_cmt = 1; s_enq = 1; s_pc = 32'hbad; tick();
    check_eq("t4_exc_idx", 64'(bus.enq_idx_o), 64'd2);
    idle(4);
    check_eq("t4_updates", 64'(upd_seen - base), 64'd2);

    // Stall holds two committed entries, then back-to-back updates.
    do_rst();
    do_enq(32'h300, BRT_COND);
    do_enq(32'h304, BRT_CALL);
    do_exe(0, 0, 32'h310);
    do_exe(1, 1, 32'h320);
    base = upd_seen;
    for (int i = 0; i < 2; i++) begin clr(); s_stall = 1; s_cmt = 1; tick(); end
    for (int i = 0; i < 3; i++) begin clr(); s_stall = 1; tick(); end
    check_eq("t5_stalled", 64'(upd_seen - base), 64'd0);
    idle(2);
    check_eq("t5_back2back", 64'(upd_seen - base), 64'd2);

    // Reset in the middle of a drain.
    do_rst();
    for (int i = 0; i < 4; i++) do_enq(32'h600 + 32'(i), BRT_JUMP);
    for (int i = 0; i < 4; i++) do_exe(i, 1, 32'h700 + 32'(i));
    for (int i = 0; i < 4; i++) begin clr(); s_stall = 1; s_cmt = 1; tick(); end
    idle(1);
    check_eq("t6_draining", 64'(bus.update_en_o), 64'd1);
    do_rst();
    check_eq("t6_en", 64'(bus.update_en_o), 64'd0);
    check_eq("t6_empty", 64'(bus.empty_o), 64'd1);
    check_eq("t6_idx", 64'(bus.enq_idx_o), 64'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clr();
      fu = first_unc();
      s_enq   = ($urandom_range(0, 99) < 60);
      s_pc    = $urandom();
      s_bt    = 2'($urandom_range(0, 3));
      s_stall = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 50) begin
        s_exe     = 1;
        s_exe_tk  = 1'($urandom_range(0, 1));
        s_exe_tgt = $urandom();
        if (mq.size() > 0 && $urandom_range(0, 9) < 8)
          s_exe_idx = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
        else
          s_exe_idx = 4'($urandom_range(0, 15));
      end
      if (fu < mq.size() && mq[fu].res && $urandom_range(0, 99) < 45) s_cmt = 1;
      if (fu < mq.size() && $urandom_range(0, 99) < 4) begin
        s_rec     = 1;
        s_rec_idx = 4'(mq[$urandom_range(fu, mq.size() - 1)].id);
      end
      if ($urandom_range(0, 999) < 15) s_exc = 1;
      if ($urandom_range(0, 999) < 3) s_rst_n = 0;
      tick();
    end
    idle(3);

`ifdef CTI_QUEUE_PERF_EN
    check_eq("perf_updates", 64'(perf_upd), 64'(upd_since_rst));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cti_queue.md
Name: cti_queue

Overview:
- In-order queue of control-transfer instructions (CTIs) in the fetch/branch-prediction complex.
- Allocates one entry per fetched CTI and records the execute-stage resolution.
- Marks entries committed in program order.
- Drains committed entries, one per cycle, as the non-speculative update stream to the RAS, BTB and BPB: update_en / update_pc / update_br_type.
- Guarantees the architectural RAS pointer advances only for committed calls and returns, in order.

Parameters:
- DEPTH, 16, number of queue entries (power of two).
- INDEX, 4, log2(DEPTH).
- PC_W, 32, PC width.
- BRT_W, 2, branch-type width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enq_valid_i  in  1  fetch presents a CTI.
- enq_pc_i  in  PC_W  CTI PC.
- enq_brtype_i  in  BRT_W  CTI type (COND/JUMP/CALL/RETURN).
- enq_ready_o  out  1  queue not full.
- enq_idx_o  out  INDEX  entry id assigned to the CTI; carried down the pipeline.
- exe_valid_i  in  1  execute resolves a CTI.
- exe_idx_i  in  INDEX  id being resolved.
- exe_taken_i  in  1  resolved direction.
- exe_target_i  in  PC_W  resolved target.
- recover_i  in  1  misprediction at exe_idx-tagged CTI.
- recover_idx_i  in  INDEX  id of the mispredicted CTI.
- exception_i  in  1  pipeline flush at commit.
- commit_valid_i  in  1  oldest uncommitted CTI retires.
- update_stall_i  in  1  consumer cannot accept an update.
- update_en_o  out  1  update valid.
- update_pc_o  out  PC_W  PC.
- update_br_type_o  out  BRT_W  type.
- update_taken_o  out  1  direction.
- update_target_o  out  PC_W  target.
- empty_o  out  1  no entries held.

Behaviour:
- Pointers: head (drain), cmt (next to commit), tail (next alloc). Each is INDEX+1 bits; the MSB is the wrap bit.
- count = tail - head.
- Full when count == DEPTH; empty when count == 0.
- Entry state: FREE -> ALLOC (enqueue) -> RESOLVED (exe) -> COMMITTED (commit) -> FREE (drain).
- ALLOC -> COMMITTED directly is illegal; assertion fires.
- Enqueue:
  - enq_ready_o = ~full, from registered pointers.
  - An entry is accepted when enq_valid_i & enq_ready_o.
  - enq_idx_o = tail[INDEX-1:0], driven combinationally; always valid.
  - Entry is visible to exe from the next cycle.
  - Enqueue while full is dropped.
  - Enqueue in the same cycle as a drain while full is still dropped.
- Resolve:
  - exe_valid_i writes taken/target and moves the entry to RESOLVED.
  - Ignored if the entry is not ALLOC (squashed or stale id).
- Commit:
  - commit_valid_i moves entry cmt to COMMITTED and increments cmt.
  - Commit with cmt == tail is illegal; it is ignored and an assertion fires.
- Drain:
  - When head is COMMITTED and ~update_stall_i, the update_* registers load that entry, update_en_o = 1 in the next cycle, and head increments.
  - Otherwise update_en_o = 0.
  - Minimum commit_valid_i-to-update_en_o latency is 2 cycles.
  - Throughput is one update per cycle.
- Recover:
  - tail <= recover_idx_i + 1, with the wrap bit computed relative to head.
  - Younger entries become FREE.
  - The mispredicted entry is kept.
  - Enqueue in the same cycle is dropped.
  - Commit in the same cycle is applied.
- Exception:
  - tail <= cmt; all uncommitted entries become FREE.
  - COMMITTED entries still drain.
  - Exception overrides recover, commit and enqueue in the same cycle.
- Wrap-around: pointers increment modulo 2*DEPTH; index equality plus wrap bit distinguishes full from empty.
- Reset (any cycle, including mid-drain):
  - All pointers 0 and all entries FREE.
  - enq_ready_o = 1, empty_o = 1.
  - All update_* outputs 0.

Optional Feature:
- Macro: CTI_QUEUE_PERF_EN.
- Defined:
  - Adds outputs perf_updates_o (32), perf_full_cycles_o (32) and perf_squashed_o (32).
  - perf_updates_o counts each update_en_o.
  - perf_full_cycles_o counts cycles with enq_valid_i & full.
  - perf_squashed_o counts entries freed by recover or exception.
  - Counters saturate and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package, ctiq_pkg:
  - Branch-type constants COND/JUMP/CALL/RETURN, matching the codebase branch-type encoding.
  - Entry-state enum.
  - ctiq_entry_t struct {pc, brtype, taken, target, state}.
- Sub-module cti_queue_ram: entry storage with one enqueue write port, one exe write port and one drain read port (asynchronous read).
- Pointer and state control stays in cti_queue.

Test Plan:
- Enqueue CALL pc=0x1000 (idx0); exe idx0 taken target 0x2000; commit -> after 2 cycles update_en_o=1, pc=0x1000, type=CALL, target=0x2000; empty_o=1 the cycle after.
- Enqueue 16 CTIs with no commit -> enq_ready_o=0 after the 16th; 17th enq_valid_i dropped; one commit+drain -> enq_ready_o=1 again; next enq_idx_o=0 (wrap).
- Enqueue ids 0..5, recover_i idx=2 -> tail=3, next enq_idx_o=3; late exe on idx4 ignored; commit 0..2 -> exactly 3 updates.
- Enqueue 0..3, commit 0..1, exception_i -> tail=2; ids 0,1 still produce updates; no update for 2,3.
- update_stall_i held 3 cycles with 2 committed entries -> update_en_o=0 during the stall; both updates then appear on consecutive cycles in order.
- reset low mid-drain with 4 committed entries -> next cycle update_en_o=0, empty_o=1, enq_idx_o=0.
